seq_mult: RTL and testbench

Parametrised sequential shift-add unsigned multiplier for the ALU. Replaces the fixed 8-bit combinational array multiplier with a WIDTH-generic, one-bit-per-cycle datapath with a start/done handshake. Returns the full 2*WIDTH-bit product as low and high halves plus an overflow flag. Sits beside the adder and other ALU units under the ALU operation mux.

---
 rtl/seq_mult_if.sv | 24 ++
 rtl/seq_mult.sv | 109 ++++++++++
 tb/tb_seq_mult.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_if.sv
// seq_mult handshake and result bundle.
// The master drives the request; the slave returns the product.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] second;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] outWire;
  logic [WIDTH-1:0] hiWire;
  logic             errorWire;

  modport master (
    output start, first, second,
    input  busy, done, outWire, hiWire, errorWire
  );

  modport slave (
    input  start, first, second,
    output busy, done, outWire, hiWire, errorWire
  );
endinterface

// File: rtl/seq_mult.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// SEQ_MULT_SAT_EN: saturate outWire to all ones on overflow.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             err_q, err_d;

  logic [PW-1:0]    acc_nx;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             prod_ovf;

  assign acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_lo  = acc_nx[WIDTH-1:0];
  assign prod_hi  = acc_nx[PW-1:WIDTH];
  assign prod_ovf = |prod_hi;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    hi_d     = hi_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, bus.first};
          mplier_d = bus.second;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          hi_d    = prod_hi;
          err_d   = prod_ovf;
`ifdef SEQ_MULT_SAT_EN
          out_d   = prod_ovf ? {WIDTH{1'b1}} : prod_lo;
`else
          out_d   = prod_lo;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      hi_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      hi_q     <= hi_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy      = (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.outWire   = out_q;
  assign bus.hiWire    = hi_q;
  assign bus.errorWire = err_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=8 and WIDTH=16.
// Expected products come from plain integer multiplication.
module tb_seq_mult;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   overlap;

  seq_mult_if #(.WIDTH(8))  if8 ();
  seq_mult_if #(.WIDTH(16)) if16 ();

  seq_mult #(.WIDTH(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  seq_mult #(.WIDTH(16)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if8.busy && if8.done) overlap++;
    if (if16.busy && if16.done) overlap++;
  end

  typedef struct {
    int a;
    int b;
    int lo;
    int hi;
    int err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_out(input int lo, input int err,
                                 input int w);
`ifdef SEQ_MULT_SAT_EN
    if (err != 0) return (1 << w) - 1;
`endif
    return lo;
  endfunction

  // Start one WIDTH=8 op; return busy cycles seen and whether done came.
  task automatic op8(input int a, input int b,
                     output int nbusy, output bit got);
    int n;
    if8.start  = 1'b1;
    if8.first  = 8'(a);
    if8.second = 8'(b);
    step();
    if8.start = 1'b0;
    nbusy = 0;
    n = 0;
    while (!if8.done && n < 40) begin
      if (if8.busy) nbusy++;
      step();
      n++;
    end
    got = if8.done;
  endtask

  task automatic wait_done8(output bit got);
    int n;
    n = 0;
    while (!if8.done && n < 40) begin
      step();
      n++;
    end
    got = if8.done;
  endtask

  task automatic check8(input string tag, input int a, input int b);
    int p;
    int lo;
    int hi;
    int err;
    p   = a * b;
    lo  = p & 8'hFF;
    hi  = (p >> 8) & 8'hFF;
    err = (hi != 0) ? 1 : 0;
    chk({tag, "_out"}, if8.outWire, exp_out(lo, err, 8));
    chk({tag, "_hi"}, if8.hiWire, hi);
    chk({tag, "_err"}, if8.errorWire, err);
  endtask

  initial begin
    int  nb;
    bit  got;
    int  k;
    int  nd;
    int  a;
    int  b;
    int  p;
    int  lo;
    int  hi;
    int  err;

    n_chk   = 0;
    n_fail  = 0;
    overlap = 0;

    vecs[0] = '{15, 17, 8'hFF, 8'h00, 0};
    vecs[1] = '{255, 255, 8'h01, 8'hFE, 1};
    vecs[2] = '{16, 16, 8'h00, 8'h01, 1};
    vecs[3] = '{0, 200, 8'h00, 8'h00, 0};
    vecs[4] = '{3, 5, 8'h0F, 8'h00, 0};
    vecs[5] = '{128, 2, 8'h00, 8'h01, 1};
    vecs[6] = '{1, 255, 8'hFF, 8'h00, 0};
    vecs[7] = '{200, 0, 8'h00, 8'h00, 0};

    rst         = 1'b1;
    if8.start   = 1'b0;
    if8.first   = '0;
    if8.second  = '0;
    if16.start  = 1'b0;
    if16.first  = '0;
    if16.second = '0;
    step();
    step();
    chk("rst_busy", if8.busy, 0);
    chk("rst_done", if8.done, 0);
    chk("rst_out", if8.outWire, 0);
    chk("rst_hi", if8.hiWire, 0);
    chk("rst_err", if8.errorWire, 0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      op8(vecs[i].a, vecs[i].b, nb, got);
      chk("tbl_done", got, 1);
      chk("tbl_busy_cycles", nb, 8);
      chk("tbl_out", if8.outWire,
          exp_out(vecs[i].lo, vecs[i].err, 8));
      chk("tbl_hi", if8.hiWire, vecs[i].hi);
      chk("tbl_err", if8.errorWire, vecs[i].err);
      step();
      chk("tbl_done_drop", if8.done, 0);
      step();
      chk("tbl_hold_out", if8.outWire,
          exp_out(vecs[i].lo, vecs[i].err, 8));
    end

    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      op8(a, b, nb, got);
      chk("rnd_done", got, 1);
      check8("rnd", a, b);
      step();
    end

    // Back-to-back with start held high through CALC and DONE.
    if8.start  = 1'b1;
    if8.first  = 8'd16;
    if8.second = 8'd16;
    step();
    if8.first  = 8'd0;
    if8.second = 8'd200;
    wait_done8(got);
    chk("b2b_done1", got, 1);
    check8("b2b1", 16, 16);
    k = 0;
    do begin
      step();
      k++;
    end while (!if8.done && k < 30);
    if8.start = 1'b0;
    chk("b2b_gap", k, 9);
    check8("b2b2", 0, 200);
    step();

    // Start pulse during CALC must be ignored.
    if8.start  = 1'b1;
    if8.first  = 8'd3;
    if8.second = 8'd5;
    step();
    if8.start = 1'b0;
    step();
    step();
    step();
    if8.start  = 1'b1;
    if8.first  = 8'd7;
    if8.second = 8'd7;
    step();
    if8.start = 1'b0;
    wait_done8(got);
    chk("ign_done", got, 1);
    chk("ign_out", if8.outWire, 15);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if8.done) nd++;
    end
    chk("ign_single_done", nd, 0);

    // Reset in the middle of CALC.
    if8.start  = 1'b1;
    if8.first  = 8'd100;
    if8.second = 8'd3;
    step();
    if8.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_busy_pre", if8.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", if8.busy, 0);
    chk("abort_done", if8.done, 0);
    chk("abort_out", if8.outWire, 0);
    chk("abort_hi", if8.hiWire, 0);
    chk("abort_err", if8.errorWire, 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (if8.done) nd++;
    end
    chk("abort_no_done", nd, 0);
    op8(2, 2, nb, got);
    chk("abort_new_done", got, 1);
    chk("abort_new_out", if8.outWire, 4);
    step();

    // WIDTH=16: fixed case then a few random operands.
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        a = 300;
        b = 300;
      end else begin
        a = int'($urandom_range(0, 65535));
        b = int'($urandom_range(0, 65535));
      end
      if16.start  = 1'b1;
      if16.first  = 16'(a);
      if16.second = 16'(b);
      step();
      if16.start = 1'b0;
      nb = 0;
      k  = 0;
      while (!if16.done && k < 60) begin
        if (if16.busy) nb++;
        step();
        k++;
      end
      p   = int'((longint'(a) * longint'(b)) & 64'hFFFF_FFFF);
      lo  = p & 16'hFFFF;
      hi  = (p >>> 16) & 16'hFFFF;
      err = (hi != 0) ? 1 : 0;
      chk("w16_done", if16.done, 1);
      chk("w16_busy_cycles", nb, 16);
      chk("w16_out", if16.outWire, exp_out(lo, err, 16));
      chk("w16_hi", if16.hiWire, hi);
      chk("w16_err", if16.errorWire, err);
      step();
    end

    chk("busy_done_excl", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
